mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
Multi-cycle iterative (radix-2 shift-add) multiplier with its own sequencing FSM. It serves the `mul` instruction (opcode 011100) in the EX stage, replacing a single-cycle combinational multiply. While a multiply is in flight it holds the pipeline with Stall. It returns the low 32 bits of the signed product with a one-cycle Done pulse.

Parameters:
WIDTH, 32, operand and result width in bits
EARLY_TERM, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run WIDTH iterations

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-low reset
Start  input  1  EX stage holds a mul (decoded ALUOp==5); stays high while the instruction is stalled
Flush  input  1  squash the EX-stage instruction (branch/jump redirect)
OperandA  input  WIDTH  multiplicand, signed
OperandB  input  WIDTH  multiplier, signed
Stall  output  1  freeze PC, IF/ID and ID/EX this cycle
Busy  output  1  FSM not in IDLE
Done  output  1  one-cycle pulse; Result valid this cycle
Result  output  WIDTH  low WIDTH bits of OperandA*OperandB

Behaviour:
- Clock and reset: single clock Clk. Reset is synchronous and active-low. It has priority over all other inputs.
- Reset values: state=IDLE, Stall=0, Busy=0, Done=0, Result=0, internal accumulator/count=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - Start is sampled only in IDLE, and only if Flush=0.
  - On Start=1, latch |A|, |B|, and sign = A[W-1]^B[W-1]; clear the accumulator; go to RUN.
- RUN, one iteration per cycle:
  - If mplier[0]=1, acc += mcand.
  - mcand <<= 1, mplier >>= 1, count++.
  - Exit to FIX when count==WIDTH, or when EARLY_TERM=1 and the shifted mplier==0.
- FIX: Result <= sign ? -acc : acc (two's complement, truncated to WIDTH). Go to DONE.
- DONE: Done=1 for exactly this cycle. Always go to IDLE; Start is ignored here, because it is still the same instruction.
- Stall = (state==IDLE & Start & ~Flush) | (state==RUN) | (state==FIX).
  - Stall is combinational on Start in IDLE so the first cycle is already held.
  - Stall=0 in DONE, so the mul advances in the same cycle Result is valid.
- Latency: Start is sampled at cycle 0 and Done is high at cycle N+2.
  - N = WIDTH when EARLY_TERM=0.
  - Otherwise N = index of the highest set bit of |B| plus 1, with a minimum of 1 (B=0 gives N=1).
- Back-to-back mul: the second Start is seen in the IDLE cycle after DONE. There is no merging.
- Flush:
  - In any non-IDLE state, Flush forces IDLE next cycle. Done is not pulsed and Result is unchanged.
  - Stall=0 in the flush cycle.
  - Flush during DONE still goes to IDLE, but Done stays 1 that cycle; the downstream write is squashed by the pipeline.
- Reset mid-operation: back to IDLE with all outputs at their reset values on the next edge.
- Arithmetic:
  - Magnitudes are computed in WIDTH bits, so -2^(W-1) stays 0x80000000; truncation keeps the low bits correct.
  - The accumulator is WIDTH bits; overflow wraps, matching MIPS `mul`.
- Result holds its value between operations.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3);
  - the ALUOp constant ALUOP_MUL=4'd5 used by the decoder to form Start;
  - the opcode constant OP_MUL=6'b011100.
- One natural sub-module, mul_shift_add_dp: registers mcand/mplier/acc plus the adder, with load/step/clear controls. The FSM and counter stay in mul_sequencer.

Test Plan:
- EARLY_TERM=0, A=7, B=6, hold Start -> Stall high cycles 0-33; Done only at cycle 34; Result=42; Busy low at cycle 35.
- EARLY_TERM=1, A=3, B=2 -> Done at cycle 4; Result=6. Then A=5, B=0 -> Done at cycle 3; Result=0.
- Signed: A=-3 (0xFFFFFFFD), B=5 -> Result=0xFFFFFFF1. Then A=0x80000000, B=-1 -> Result=0x80000000. Then A=0x00010000, B=0x00010000 -> Result=0.
- Back-to-back: hold Start through Done, then keep it high with new operands 4*4 -> exactly one Done per instruction; second Result=16; no extra Done.
- Flush at RUN cycle 5 -> next cycle IDLE; Stall=0; no Done; Result keeps its prior value. Flush asserted together with Start in IDLE -> no start; Stall=0.
- Reset=0 during RUN -> next edge: IDLE, Stall=0, Busy=0, Done=0, Result=0. After Reset=1, a new 2*9 -> Result=18.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_sequencer_pkg
// Shared definitions for the iterative multiplier used by the EX stage.
//   state_t   : sequencer FSM encoding (IDLE/RUN/FIX/DONE)
//   ALUOP_MUL : ALUOp value the decoder uses to form the Start request
//   OP_MUL    : primary opcode of the MIPS `mul` instruction
// -----------------------------------------------------------------------------
package mul_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [3:0] ALUOP_MUL = 4'd5;
   localparam logic [5:0] OP_MUL    = 6'b011100;

endpackage

// File: rtl/mul_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mul_shift_add_dp
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator
// registers plus the single adder. Operands are reduced to magnitudes on
// load; the product sign is kept separately for the final fix-up.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_load              : capture |i_a|, |i_b|, sign; clear accumulator
//   i_step              : one iteration (conditional add, shift both operands)
//   i_clear             : drop all state (squashed instruction)
//   i_a, i_b            : signed operands
//   o_acc               : accumulated magnitude product (low WIDTH bits)
//   o_sign              : sign of the final product
//   o_mplier_next_zero  : multiplier is zero after this step's shift
// -----------------------------------------------------------------------------
module mul_shift_add_dp #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic             o_sign,
   output logic             o_mplier_next_zero
);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic             r_sign;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_addend;

   // Magnitudes stay WIDTH bits: the most negative value maps onto itself,
   // which is still the correct unsigned magnitude.
   assign w_abs_a  = i_a[WIDTH-1] ? -i_a : i_a;
   assign w_abs_b  = i_b[WIDTH-1] ? -i_b : i_b;
   assign w_addend = r_mplier[0] ? r_mcand : '0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_sign   <= 1'b0;
      end else if (i_load) begin
         r_mcand  <= w_abs_a;
         r_mplier <= w_abs_b;
         r_acc    <= '0;
         r_sign   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      end else if (i_step) begin
         r_acc    <= r_acc + w_addend;   // wraps modulo 2^WIDTH
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

   assign o_acc              = r_acc;
   assign o_sign             = r_sign;
   assign o_mplier_next_zero = ((r_mplier >> 1) == '0);

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle signed multiplier for the EX stage (`mul`), returning the low
// WIDTH bits of OperandA*OperandB. One shift-add iteration per cycle, a sign
// fix-up cycle, then a one-cycle Done pulse.
// Handshake: the EX stage raises Start and keeps it high while it is stalled;
// the unit answers with Stall (combinational in IDLE, so the first cycle is
// already held) until the cycle Done=1, in which Stall drops and the
// instruction advances with Result valid. Flush squashes the request.
// Ports:
//   Clk, Reset          : clock, synchronous active-low reset
//   Start, Flush        : request / squash from the pipeline
//   OperandA, OperandB  : signed operands, sampled when the request is taken
//   Stall, Busy, Done   : pipeline hold, FSM not idle, result-valid pulse
//   Result              : product, held between operations
// -----------------------------------------------------------------------------
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Flush,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   localparam int              CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_result;

   logic             w_load;
   logic             w_step;
   logic             w_clear;
   logic             w_fix;
   logic             w_stall;
   logic             w_done;
   logic [WIDTH-1:0] w_acc;
   logic             w_sign;
   logic             w_mplier_next_zero;
   logic [WIDTH-1:0] w_fixed;

   mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .i_clk              (Clk),
      .i_rst_n            (Reset),
      .i_load             (w_load),
      .i_step             (w_step),
      .i_clear            (w_clear),
      .i_a                (OperandA),
      .i_b                (OperandB),
      .o_acc              (w_acc),
      .o_sign             (w_sign),
      .o_mplier_next_zero (w_mplier_next_zero)
   );

   assign w_fixed = w_sign ? -w_acc : w_acc;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_clear     = 1'b0;
      w_fix       = 1'b0;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Start && !Flush) begin
               w_load      = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (Flush) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_step  = 1'b1;
               w_stall = 1'b1;
               // Leave after the WIDTH-th step, or as soon as no multiplier
               // bits remain once this step's shift has happened.
               if ((r_count == LAST_ITER) || (EARLY_TERM && w_mplier_next_zero)) begin
                  w_state_nxt = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            if (Flush) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_fix       = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // Start is still the same instruction here, so it is not sampled.
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset || w_load || w_clear) begin
         r_count <= '0;
      end else if (w_step) begin
         r_count <= r_count + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_result <= '0;
      end else if (w_fix) begin
         r_result <= w_fixed;
      end
   end

   // A request is never accepted while Reset is low, so it must not stall.
   assign Stall  = w_stall & Reset;
   assign Busy   = (r_state != ST_IDLE);
   assign Done   = w_done;
   assign Result = r_result;

endmodule
